// File: rtl/x_lut6_cfg_writer.sv
// x_lut6_cfg_writer: serially programs a 6-input LUT truth table and
// keeps a shadow copy that answers combinational readback.
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   LD_VALID/LD_READY load handshake, LD_DATA is the 64-bit table
//   ABORT             cancels a shift in progress
//   CDI, CE           serial data and shift enable to the target LUT
//   DONE              one-cycle pulse when a load completes
//   DIRTY             target not known to match the shadow table
//   ADR0..ADR5, O     shadow readback (ADR5 is the MSB)
module x_lut6_cfg_writer #(
   parameter logic [63:0] INIT = 64'h0000000000000000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        LD_VALID,
   output logic        LD_READY,
   input  logic [63:0] LD_DATA,
   input  logic        ABORT,
   output logic        CDI,
   output logic        CE,
   output logic        DONE,
   output logic        DIRTY,
   input  logic        ADR0,
   input  logic        ADR1,
   input  logic        ADR2,
   input  logic        ADR3,
   input  logic        ADR4,
   input  logic        ADR5,
   output logic        O
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [63:0] held;
   logic [63:0] shadow;
   logic [5:0]  cnt;
   logic [5:0]  adr;
   logic        dirty_q;
   logic        live;
   logic        accept;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // MSB first: cycle k sends held[63-k], which is held[~k] for 6 bits.
   always_comb begin
      state_nx = state;
      LD_READY = 1'b0;
      CE       = 1'b0;
      CDI      = 1'b0;
      DONE     = 1'b0;
      accept   = 1'b0;
      unique case (state)
         IDLE: begin
            LD_READY = live;
            if (LD_VALID && live) begin
               accept   = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            CE  = 1'b1;
            CDI = held[~cnt];
            if (ABORT) begin
               state_nx = IDLE;
            end else if (cnt == 6'd63) begin
               state_nx = COMMIT;
            end
         end
         COMMIT: begin
            DONE     = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // live keeps LD_READY low until the first edge out of reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         held    <= 64'd0;
         cnt     <= 6'd0;
         shadow  <= INIT;
         dirty_q <= 1'b1;
         live    <= 1'b0;
      end else begin
         live <= 1'b1;
         if (accept) begin
            held    <= LD_DATA;
            cnt     <= 6'd0;
            dirty_q <= 1'b1;
         end
         if (state == SHIFT) begin
            cnt <= cnt + 6'd1;
         end
         if (state == COMMIT) begin
            shadow  <= held;
            dirty_q <= 1'b0;
         end
      end
   end

   assign DIRTY = dirty_q;
   assign adr   = {ADR5, ADR4, ADR3, ADR2, ADR1, ADR0};
   assign O     = shadow[adr];

endmodule

// File: tb/tb_x_lut6_cfg_writer.sv
// tb_x_lut6_cfg_writer: randomized scoreboard bench for the LUT6
// configuration writer with a target-LUT shift model in the monitor.
module tb_x_lut6_cfg_writer;

   localparam logic [63:0] INIT_V = 64'h8000000000000001;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        LD_VALID = 1'b0;
   logic        LD_READY;
   logic [63:0] LD_DATA = 64'd0;
   logic        ABORT = 1'b0;
   logic        CDI;
   logic        CE;
   logic        DONE;
   logic        DIRTY;
   logic [5:0]  adr = 6'd0;
   logic        O;

   x_lut6_cfg_writer #(.INIT(INIT_V)) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .LD_VALID(LD_VALID),
      .LD_READY(LD_READY),
      .LD_DATA(LD_DATA),
      .ABORT(ABORT),
      .CDI(CDI),
      .CE(CE),
      .DONE(DONE),
      .DIRTY(DIRTY),
      .ADR0(adr[0]),
      .ADR1(adr[1]),
      .ADR2(adr[2]),
      .ADR3(adr[3]),
      .ADR4(adr[4]),
      .ADR5(adr[5]),
      .O(O)
   );

   always #5 CLK = ~CLK;

   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   int          cecnt = 0;
   logic [63:0] exp_q[$];
   logic [63:0] shadow_m;
   logic [63:0] tgt = 64'd0;
   logic [63:0] mon_exp;

   task automatic chk1(input string name, input logic act,
                       input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, req);
      end
   endtask

   task automatic chk64(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Target LUT model: shifts CDI in on every edge with CE high.
   always @(negedge CLK) begin
      if (CE === 1'b1) begin
         tgt = {tgt[62:0], CDI};
         cecnt++;
      end else if (DONE === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk1("unexpected_done", 1'b1, 1'b0);
         end else begin
            mon_exp = exp_q.pop_front();
            chk64("target_word", tgt, mon_exp);
            chk64("ce_run_len", 64'(cecnt), 64'd64);
         end
         cecnt = 0;
      end else begin
         cecnt = 0;
      end
   end

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         if (LD_READY === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk1("ready_timeout", 1'b0, 1'b1);
   endtask

   task automatic sweep(input string name);
      for (int i = 0; i < 64; i++) begin
         @(negedge CLK);
         adr = 6'(i);
         #1;
         chk1(name, O, shadow_m[i]);
      end
   endtask

   task automatic load(input logic [63:0] d, input int abort_at,
                       input bit abort_commit, input int rst_at);
      bit ok;
      wait_ready(ok);
      if (!ok) return;
      LD_VALID = 1'b1;
      LD_DATA  = d;
      ABORT    = 1'($urandom_range(0, 1));
      if (abort_at < 0 && rst_at < 0) exp_q.push_back(d);
      @(posedge CLK);
      #1;
      LD_VALID = 1'b0;
      LD_DATA  = {$urandom, $urandom};
      ABORT    = 1'b0;
      chk1("dirty_on_accept", DIRTY, 1'b1);
      for (int k = 0; k < 64; k++) begin
         @(negedge CLK);
         chk1("ce_shift", CE, 1'b1);
         chk1("cdi_bit", CDI, d[63-k]);
         chk1("done_in_shift", DONE, 1'b0);
         chk1("ready_in_shift", LD_READY, 1'b0);
         adr = 6'($urandom);
         #1;
         chk1("o_hold_shift", O, shadow_m[adr]);
         if (k == abort_at) begin
            ABORT = 1'b1;
            @(posedge CLK);
            #1;
            ABORT = 1'b0;
            chk1("ce_after_abort", CE, 1'b0);
            chk1("done_after_abort", DONE, 1'b0);
            chk1("dirty_after_abort", DIRTY, 1'b1);
            chk1("ready_after_abort", LD_READY, 1'b1);
            return;
         end
         if (k == rst_at) begin
            #1;
            RST_N = 1'b0;
            #1;
            shadow_m = INIT_V;
            chk1("ce_in_reset", CE, 1'b0);
            chk1("cdi_in_reset", CDI, 1'b0);
            chk1("done_in_reset", DONE, 1'b0);
            chk1("dirty_in_reset", DIRTY, 1'b1);
            chk1("ready_in_reset", LD_READY, 1'b0);
            adr = 6'h3F;
            #1;
            chk1("o_init_reset", O, 1'b1);
            @(negedge CLK);
            #2;
            RST_N = 1'b1;
            #1;
            chk1("ready_pre_edge", LD_READY, 1'b0);
            @(posedge CLK);
            #1;
            chk1("ready_post_reset", LD_READY, 1'b1);
            return;
         end
      end
      @(negedge CLK);
      chk1("ce_commit", CE, 1'b0);
      chk1("done_commit", DONE, 1'b1);
      adr = 6'($urandom);
      #1;
      chk1("o_hold_commit", O, shadow_m[adr]);
      if (abort_commit) ABORT = 1'b1;
      @(posedge CLK);
      #1;
      ABORT    = 1'b0;
      shadow_m = d;
      chk1("dirty_clear", DIRTY, 1'b0);
      chk1("done_one_cycle", DONE, 1'b0);
      chk1("ready_after_load", LD_READY, 1'b1);
   endtask

   task automatic back_to_back(input logic [63:0] a,
                               input logic [63:0] b);
      bit ok;
      int n;
      int commits;
      logic rdy;
      wait_ready(ok);
      if (!ok) return;
      LD_VALID = 1'b1;
      LD_DATA  = a;
      exp_q.push_back(a);
      @(posedge CLK);
      #1;
      LD_DATA = b;
      exp_q.push_back(b);
      n = 0;
      commits = 0;
      rdy = 1'b0;
      while (n < 200 && !rdy) begin
         @(negedge CLK);
         if (CE === 1'b0 && DONE === 1'b1) commits++;
         rdy = LD_READY;
         @(posedge CLK);
         n++;
      end
      #1;
      LD_VALID = 1'b0;
      chk64("b2b_accept_gap", 64'(n), 64'd66);
      chk64("b2b_commit_cycles", 64'(commits), 64'd1);
      n = 0;
      while (n < 200) begin
         @(negedge CLK);
         n++;
         if (DONE === 1'b1) break;
      end
      chk1("b2b_second_done", DONE, 1'b1);
      @(posedge CLK);
      #1;
      shadow_m = b;
      chk1("b2b_dirty", DIRTY, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int ab;
      shadow_m = INIT_V;
      #12;
      chk1("rst_ce", CE, 1'b0);
      chk1("rst_cdi", CDI, 1'b0);
      chk1("rst_done", DONE, 1'b0);
      chk1("rst_ready", LD_READY, 1'b0);
      chk1("rst_dirty", DIRTY, 1'b1);
      adr = 6'h3F;
      #1;
      chk1("rst_o_3f", O, 1'b1);
      adr = 6'h01;
      #1;
      chk1("rst_o_01", O, 1'b0);
      @(negedge CLK);
      #1;
      RST_N = 1'b1;
      #1;
      chk1("ready_before_edge", LD_READY, 1'b0);
      @(posedge CLK);
      #1;
      chk1("ready_first_edge", LD_READY, 1'b1);
      sweep("o_init");

      load(64'hF0E1D2C3B4A59687, -1, 1'b0, -1);
      sweep("o_directed");

      back_to_back({$urandom, $urandom}, {$urandom, $urandom});
      sweep("o_b2b");

      load({$urandom, $urandom}, 20, 1'b0, -1);
      sweep("o_after_abort");

      load({$urandom, $urandom}, -1, 1'b0, 40);
      sweep("o_after_reset");

      load({$urandom, $urandom}, -1, 1'b1, -1);
      sweep("o_abort_commit");

      for (int i = 0; i < 6; i++) begin
         ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 63)) : -1;
         load({$urandom, $urandom}, ab, 1'($urandom_range(0, 1)), -1);
         sweep("o_random");
      end

      repeat (4) @(negedge CLK);
      chk64("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
